// File: rtl/riscv_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_fetch                                                                |
// | Instruction fetch: PC, single-outstanding imem request, decode slot + skid. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;

  logic w_req;
  logic w_grant;
  logic w_resp;
  logic w_skid_to_slot;
  logic w_resp_to_slot;
  logic w_resp_to_skid;
  logic w_unused;

  assign w_unused = ^redirect_pc_i[1:0];

  // Re-issue in the rvalid cycle only if the response has somewhere to go.
  assign w_req = rst_ni && !redirect_i && !r_skid_valid &&
                 ((r_state == ST_IDLE) ||
                  ((r_state == ST_WAIT) && imem_rvalid_i && !(stall_i && r_id_valid)));
  assign w_grant        = w_req && imem_gnt_i;
  assign w_resp         = (r_state == ST_WAIT) && imem_rvalid_i && !redirect_i;
  assign w_skid_to_slot = !stall_i && r_skid_valid;
  assign w_resp_to_slot = w_resp && (!stall_i || !r_id_valid) && !r_skid_valid;
  assign w_resp_to_skid = w_resp && !w_resp_to_slot;

  always_comb begin
    w_state_next = r_state;
    if (redirect_i) begin
      case (r_state)
        ST_WAIT: w_state_next = imem_rvalid_i ? ST_IDLE : ST_KILL;
        ST_KILL: w_state_next = imem_rvalid_i ? ST_IDLE : ST_KILL;
        default: w_state_next = ST_IDLE;
      endcase
    end else if (w_grant) begin
      w_state_next = ST_WAIT;
    end else if (imem_rvalid_i && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      if (redirect_i) begin
        r_pc <= {redirect_pc_i[31:2], 2'b00};
      end else if (w_grant) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_valid <= 1'b0;
      r_id_instr <= C_NOP;
      r_id_pc    <= 32'h0000_0000;
    end else if (redirect_i) begin
      r_id_valid <= 1'b0;
    end else if (w_skid_to_slot) begin
      r_id_valid <= 1'b1;
      r_id_instr <= r_skid_instr;
      r_id_pc    <= r_skid_pc;
    end else if (w_resp_to_slot) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rdata_i;
      r_id_pc    <= r_req_pc;
    end else if (!stall_i) begin
      r_id_valid <= 1'b0;
    end
  end

  // Skid holds a response that arrived while decode was stalled on a valid slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_skid_valid <= 1'b0;
      r_skid_instr <= 32'h0000_0000;
      r_skid_pc    <= 32'h0000_0000;
    end else if (redirect_i) begin
      r_skid_valid <= 1'b0;
    end else if (w_resp_to_skid) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= imem_rdata_i;
      r_skid_pc    <= r_req_pc;
    end else if (w_skid_to_slot) begin
      r_skid_valid <= 1'b0;
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign id_valid_o  = r_id_valid;
  assign id_instr_o  = r_id_instr;
  assign id_pc_o     = r_id_pc;

endmodule
`default_nettype wire

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch stage of the riscv pipeline. Holds the PC, issues one instruction-memory request at a time, and presents the fetched instruction and its PC to decode through a registered output slot. It honours the hazard unit's stall (holds decode), absorbs a response that lands during a stall in a one-entry skid buffer, and discards in-flight fetches on a redirect from execute.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- stall_i  input  1  hazard-unit stall; decode slot must hold its contents
- redirect_i  input  1  taken branch/jump from execute
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch address (= pc_q)
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response valid; earliest one cycle after grant
- imem_rdata_i  input  32  instruction word
- id_valid_o  output  1  decode slot holds a valid instruction
- id_instr_o  output  32  instruction to decode
- id_pc_o  output  32  PC of id_instr_o

## Operation
- States: IDLE (nothing outstanding), WAIT (one outstanding, keep), KILL (one outstanding, discard).
- imem_req_o = !redirect_i && !skid_valid_q && (IDLE || (WAIT && imem_rvalid_i && !(stall_i && id_valid_o))). Never more than one unanswered grant.
- On imem_req_o && imem_gnt_i: req_pc_q <= pc_q; pc_q <= pc_q + 4 (mod 2^32); state -> WAIT.
- WAIT and imem_rvalid_i without grant: state -> IDLE. With grant: stays WAIT.
- Response routing (WAIT, imem_rvalid_i, no redirect): if !stall_i or !id_valid_o, and skid empty -> load slot {1, rdata, req_pc_q}; else -> skid {rdata, req_pc_q}, skid_valid_q <= 1.
- Slot advance when !stall_i: skid full -> slot loads skid, skid cleared; else response present -> slot loads response; else id_valid_o <= 0.
- stall_i && id_valid_o: slot unchanged (valid, instr, pc all held).
- Redirect (priority over everything): pc_q <= {redirect_pc_i[31:2], 2'b00}; id_valid_o <= 0; skid cleared; any response this cycle discarded; WAIT without rvalid -> KILL; WAIT with rvalid -> IDLE; IDLE stays IDLE; KILL stays KILL (or IDLE if rvalid).
- KILL and imem_rvalid_i: response discarded, state -> IDLE.
- imem_rvalid_i in IDLE: ignored.
- id_instr_o/id_pc_o only meaningful when id_valid_o=1; invalid slot keeps last values.

## Timing
- Reset (asynchronous): pc_q=RESET_PC, state IDLE, skid empty, id_valid_o=0, id_instr_o=32'h0000_0013 (NOP), id_pc_o=0, imem_req_o=0 while rst_ni=0, imem_addr_o=RESET_PC.
- First cycle after reset release: imem_req_o=1, imem_addr_o=RESET_PC.
- Latency: grant in cycle N, rvalid in N+1 -> id_valid_o=1 in N+2.
- Throughput: with single-cycle memory and no stall, one instruction per cycle (re-issue in the rvalid cycle).
- Redirect in cycle N: id_valid_o=0 in N+1; request for target issued in N+1 if state IDLE, else after the killed response returns.
- Reset asserted mid-fetch: all state cleared at once; a late response after release arrives in IDLE and is ignored.
- Stall never drops an instruction: at most slot + skid = 2 held; no request while skid full.

## Test plan
- Reset RESET_PC=32'h100, memory gnt=1, rvalid next cycle, no stall -> id_pc_o 0x100,0x104,0x108 on consecutive cycles from cycle 2, id_valid_o=1 each cycle.
- Stall_i high 3 cycles while slot holds pc 0x104 -> slot holds 0x104, response 0x108 goes to skid, imem_req_o=0; stall release -> 0x108 then 0x10C, no gap or duplicate.
- Redirect to 0x2002 while response outstanding (rvalid delayed 3 cycles) -> state KILL, stale rdata discarded, next fetch address 0x2000, id_valid_o=0 until its response.
- Redirect coincident with rvalid and stall_i=1 -> response dropped, skid and slot invalid next cycle, next request to target.
- pc_q=32'hFFFF_FFFC fetch -> next imem_addr_o=32'h0000_0000.
- rst_ni pulsed low mid-WAIT -> outputs at reset values immediately; spurious rvalid after release does not set id_valid_o.
